// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC, single-outstanding memory port, prefetch FIFO and redirect squashing
module instruction_fetch_unit #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         CLK,
    input  logic                         reset_n,
    output logic                         mem_req,
    output logic [XLEN-1:0]              mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [ILEN-1:0]              mem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [ILEN-1:0]              inst,
    output logic [XLEN-1:0]              inst_pc,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);
    localparam logic [XLEN-1:0] MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC0 = RESET_PC & MASK;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [ILEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic hs, push, pop;
    assign hs = mem_req && mem_gnt;
    assign push = state_q == WAIT && mem_rvalid && !redirect;
    assign pop = inst_valid && inst_ready && !redirect;
    assign inst_valid = count_q != '0;
    assign inst = inst_mem[head_q];
    assign inst_pc = pc_mem[head_q];
    assign mem_addr = pc_q;
    assign fifo_count = count_q;
    // state and control registers; async reset returns to IDLE at the reset PC
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= PC0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // next state; a redirect with a request still in flight must wait out the stale response in DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = redirect ? IDLE : REQ;
            REQ:     state_d = hs ? (redirect ? DROP : WAIT) : REQ;
            WAIT:    state_d = mem_rvalid ? REQ : (redirect ? DROP : WAIT);
            DROP:    state_d = mem_rvalid ? REQ : DROP;
            default: state_d = IDLE;
        endcase
    end
    // request is withheld while the FIFO is full so a push can never overflow it
    always_comb begin
        mem_req = state_q == REQ && count_q < FULL;
    end
    // PC and FIFO pointer updates; redirect flushes by collapsing head onto tail
    always_comb begin
        pc_d    = redirect ? (redirect_pc & MASK) : hs ? pc_q + STEP : pc_q;
        head_d  = redirect ? tail_q : pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    end
    // FIFO storage; the request PC is one step behind fetch_pc while in WAIT
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[tail_q] <= mem_rdata;
            pc_mem[tail_q]   <= pc_q - STEP;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vectors for the fetch unit with hand-computed expectations
module tb_instruction_fetch_unit;
    logic        CLK;
    logic        reset_n;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic auto_mode = 0;
    logic gnt_en = 0;
    logic pend = 0;
    logic [63:0] pend_addr = '0;

    instruction_fetch_unit #(.XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock; auto mode grants when gnt_en and answers each grant on the following cycle
    task automatic cyc();
        logic h;
        logic [63:0] a;
        if (auto_mode) begin
            mem_gnt = gnt_en;
            mem_rvalid = pend;
            mem_rdata = word(pend_addr);
        end
        h = mem_req && mem_gnt;
        a = mem_addr;
        if (h) hs_cnt++;
        @(posedge CLK); #1;
        redirect = 0;
        if (auto_mode) begin
            pend = h;
            pend_addr = a;
        end else begin
            mem_gnt = 0;
            mem_rvalid = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        auto_mode = 0; gnt_en = 0; pend = 0; hs_cnt = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        inst_ready = 0; redirect = 0; redirect_pc = '0;
        @(posedge CLK); #1;
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        inst_ready = 0; redirect = 0; redirect_pc = '0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_count", fifo_count, 0);

        // 1: streaming fetch with zero-wait memory
        do_reset();
        auto_mode = 1; gnt_en = 1; inst_ready = 1;
        check("t1_idle_req", mem_req, 0);
        cyc();
        check("t1_req0", mem_req, 1);
        check("t1_addr0", mem_addr, 64'h0);
        cyc();
        check("t1_wait_req", mem_req, 0);
        check("t1_wait_valid", inst_valid, 0);
        cyc();
        check("t1_valid_lat", inst_valid, 1);
        check("t1_pc0", inst_pc, 64'h0);
        check("t1_inst0", inst, word(64'h0));
        check("t1_addr4", mem_addr, 64'h4);
        cyc(); cyc();
        check("t1_pc4", inst_pc, 64'h4);
        check("t1_addr8", mem_addr, 64'h8);
        cyc(); cyc();
        check("t1_pc8", inst_pc, 64'h8);
        check("t1_inst8", inst, word(64'h8));

        // 2: fill the FIFO with no consumer, then one pop reopens fetch
        do_reset();
        auto_mode = 1; gnt_en = 1;
        for (int i = 0; i < 9; i++) cyc();
        check("t2_hs4", hs_cnt, 4);
        check("t2_req_full", mem_req, 0);
        check("t2_count4", fifo_count, 4);
        cyc();
        check("t2_hs_hold", hs_cnt, 4);
        check("t2_head", inst_pc, 64'h0);
        inst_ready = 1;
        cyc();
        inst_ready = 0;
        check("t2_req_again", mem_req, 1);
        check("t2_addr10", mem_addr, 64'h10);
        check("t2_count3", fifo_count, 3);
        check("t2_pc4", inst_pc, 64'h4);

        // 5a: full FIFO, pop and redirect together
        cyc(); cyc();
        check("t5_full", fifo_count, 4);
        inst_ready = 1; redirect = 1; redirect_pc = 64'h40;
        cyc();
        inst_ready = 0;
        check("t5_flush_count", fifo_count, 0);
        check("t5_flush_valid", inst_valid, 0);
        check("t5_req", mem_req, 1);
        check("t5_addr40", mem_addr, 64'h40);
        cyc(); cyc();
        check("t5_count1", fifo_count, 1);
        check("t5_pc40", inst_pc, 64'h40);
        // 5b: push and pop in one cycle at count 2
        cyc(); cyc();
        check("t5_count2", fifo_count, 2);
        cyc();
        inst_ready = 1;
        cyc();
        inst_ready = 0; gnt_en = 0;
        check("t5_pp_count", fifo_count, 2);
        check("t5_pp_pc44", inst_pc, 64'h44);
        inst_ready = 1;
        cyc();
        inst_ready = 0;
        check("t5_order_pc", inst_pc, 64'h48);
        check("t5_order_inst", inst, word(64'h48));
        check("t5_order_count", fifo_count, 1);

        // 3: redirect during WAIT, stale response two cycles later
        do_reset();
        inst_ready = 1;
        cyc();
        mem_gnt = 1; cyc();
        redirect = 1; redirect_pc = 64'h100; cyc();
        check("t3_drop_req", mem_req, 0);
        check("t3_count", fifo_count, 0);
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; cyc();
        check("t3_req", mem_req, 1);
        check("t3_addr100", mem_addr, 64'h100);
        check("t3_count0", fifo_count, 0);
        check("t3_valid0", inst_valid, 0);
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h100); cyc();
        check("t3_inst", inst, word(64'h100));
        check("t3_pc", inst_pc, 64'h100);

        // 4: redirect in the same cycle as the grant for 0x8
        do_reset();
        inst_ready = 1;
        cyc();
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h0); cyc();
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h4); cyc();
        check("t4_addr8", mem_addr, 64'h8);
        mem_gnt = 1; redirect = 1; redirect_pc = 64'h203; cyc();
        check("t4_drop_req", mem_req, 0);
        check("t4_count", fifo_count, 0);
        mem_rvalid = 1; mem_rdata = word(64'h8); cyc();
        check("t4_req", mem_req, 1);
        check("t4_addr200", mem_addr, 64'h200);
        check("t4_valid0", inst_valid, 0);
        inst_ready = 0;
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h200); cyc();
        check("t4_pc200", inst_pc, 64'h200);
        check("t4_count1", fifo_count, 1);

        // 6: async reset during WAIT, late response ignored
        do_reset();
        cyc();
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h0); cyc();
        mem_gnt = 1; cyc();
        check("t6_pre_count", fifo_count, 1);
        check("t6_pre_addr", mem_addr, 64'h8);
        reset_n = 0;
        #1;
        check("t6_async_req", mem_req, 0);
        check("t6_async_addr", mem_addr, 64'h0);
        check("t6_async_valid", inst_valid, 0);
        check("t6_async_count", fifo_count, 0);
        @(posedge CLK); #1;
        reset_n = 1;
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0; cyc();
        check("t6_req", mem_req, 1);
        check("t6_addr0", mem_addr, 64'h0);
        check("t6_count0", fifo_count, 0);
        mem_gnt = 1; cyc();
        mem_rvalid = 1; mem_rdata = word(64'h0); cyc();
        check("t6_pc0", inst_pc, 64'h0);
        check("t6_inst0", inst, word(64'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
